// File: rtl/freq_frame_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : freq_frame_packer
// Purpose  : Packs each frequency-measurement result into a fixed frame
//            (HEADER, seq, count bytes MSB-first, XOR checksum) and streams
//            it one byte at a time to the SPI byte transmitter over a
//            send/done/ack handshake. A one-deep pending buffer absorbs a
//            measurement arriving mid-frame; overrun and per-byte timeout
//            are reported through sticky flags.
// Ports    : clk, rst (async, active-low)
//            meas_valid_i / meas_count_i : measurement strobe and value
//            clr_err_i                   : clears overrun_o / timeout_err_o
//            tx_send_o / tx_data_o       : byte request and data to the TX
//            tx_done_i / tx_ack_o        : TX done level / ack back to TX
//            frame_busy_o / frame_done_o : frame in progress / end pulse
//            overrun_o / timeout_err_o   : sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module freq_frame_packer #(
  parameter int         NBYTES  = 4,
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         TIMEOUT = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  meas_valid_i,
  input  logic [8*NBYTES-1:0]   meas_count_i,
  input  logic                  clr_err_i,
  output logic                  tx_send_o,
  output logic [7:0]            tx_data_o,
  input  logic                  tx_done_i,
  output logic                  tx_ack_o,
  output logic                  frame_busy_o,
  output logic                  frame_done_o,
  output logic                  overrun_o,
  output logic                  timeout_err_o
);

  // Stored frame bytes: seq, NBYTES count bytes, checksum (header is constant)
  localparam int NFB = NBYTES + 2;
  localparam int IW  = $clog2(NBYTES + 3);

  localparam logic [IW-1:0] C_LAST_IDX = IW'(NBYTES + 2);
  localparam logic [23:0]   C_TMO_LAST = 24'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;
  localparam logic [2:0] S_ABORT = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [23:0]         tmo_q, tmo_d;
  logic [7:0]          seq_q;
  logic [8*NBYTES-1:0] shadow_q, shadow_d;
  logic [8*NBYTES-1:0] pend_q, pend_d;
  logic                pend_full_q, pend_full_d;
  logic                overrun_q, overrun_d;
  logic                terr_q, terr_d;
  logic [7:0]          frame_q [NFB];
  logic                tx_send_q, tx_ack_q, busy_q, done_q;
  logic [7:0]          tx_data_q;

  logic [7:0]          w_cnt_bytes [NBYTES];
  logic [7:0]          w_chk;
  logic [7:0]          w_next_byte;
  logic [IW-1:0]       w_fidx;
  logic                w_take_pend;
  logic                w_direct;

  // Count bytes in transmit order, MSB first
  for (genvar k = 0; k < NBYTES; k++) begin : g_count_bytes
    assign w_cnt_bytes[k] = shadow_q[8*(NBYTES-k)-1 -: 8];
  end

  always_comb begin
    w_chk = seq_q;
    for (int k = 0; k < NBYTES; k++) begin
      w_chk = w_chk ^ w_cnt_bytes[k];
    end
  end

  // Byte presented on the next SEND entry; index 0 is always the header,
  // which also avoids reading frame_q in the cycle it is being loaded.
  assign w_fidx      = idx_d - 1'b1;
  assign w_next_byte = (idx_d == '0) ? HEADER : frame_q[w_fidx];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmo_d       = '0;
    shadow_d    = shadow_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    overrun_d   = overrun_q & ~clr_err_i;
    terr_d      = terr_q & ~clr_err_i;
    w_take_pend = 1'b0;
    w_direct    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A pending value can be left over after an aborted frame
        if (pend_full_q) begin
          w_take_pend = 1'b1;
          state_d     = S_LOAD;
        end else if (meas_valid_i) begin
          w_direct = 1'b1;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_done_i) begin
          state_d = S_ACK;
        end else if (tmo_q == C_TMO_LAST) begin
          state_d = S_ABORT;
          terr_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      S_ACK: begin
        if (!tx_done_i) begin
          if (idx_q == C_LAST_IDX) begin
            state_d = S_END;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SEND;
          end
        end
      end
      S_END: begin
        if (pend_full_q) begin
          w_take_pend = 1'b1;
          state_d     = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ABORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_take_pend) begin
      shadow_d    = pend_q;
      pend_full_d = 1'b0;
    end

    // A strobe either goes straight to the shadow (idle, nothing pending) or
    // into the pending slot; it only overruns if the old pending value is
    // not being moved out in this same cycle.
    if (w_direct) begin
      shadow_d = meas_count_i;
    end else if (meas_valid_i) begin
      pend_d      = meas_count_i;
      pend_full_d = 1'b1;
      if (pend_full_q && !w_take_pend) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      tmo_q       <= '0;
      shadow_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      terr_q      <= 1'b0;
      tx_send_q   <= 1'b0;
      tx_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      shadow_q    <= shadow_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      overrun_q   <= overrun_d;
      terr_q      <= terr_d;
      // Handshake outputs are registered from the next state so they line
      // up exactly with the state they belong to, free of decode glitches.
      tx_send_q   <= (state_d == S_SEND);
      tx_ack_q    <= (state_d == S_ACK) || (state_d == S_ABORT);
      busy_q      <= (state_d == S_LOAD) || (state_d == S_SEND) || (state_d == S_ACK);
      done_q      <= (state_d == S_END) || (state_d == S_ABORT);
      if (state_d == S_SEND) begin
        tx_data_q <= w_next_byte;
      end
    end
  end

  // Frame snapshot and sequence number; seq of an aborted frame stays used
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_q <= '0;
      for (int k = 0; k < NFB; k++) begin
        frame_q[k] <= '0;
      end
    end else if (state_q == S_LOAD) begin
      seq_q      <= seq_q + 8'd1;
      frame_q[0] <= seq_q;
      for (int k = 0; k < NBYTES; k++) begin
        frame_q[k+1] <= w_cnt_bytes[k];
      end
      frame_q[NFB-1] <= w_chk;
    end
  end

  assign tx_send_o     = tx_send_q;
  assign tx_data_o     = tx_data_q;
  assign tx_ack_o      = tx_ack_q;
  assign frame_busy_o  = busy_q;
  assign frame_done_o  = done_q;
  assign overrun_o     = overrun_q;
  assign timeout_err_o = terr_q;

endmodule
`default_nettype wire
